// File: rtl/stv_pwm_deadtime.sv
// Complementary PWM with double-buffered duty and dead-time insertion.
// Define STV_PWM_POLARITY_EN to add pol_h/pol_l output polarity inputs.
module stv_pwm_deadtime #(
  parameter int WIDTH = 8,
  parameter int DT_WIDTH = 6,
  parameter logic [WIDTH-1:0] INIT_DUTY = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [WIDTH-1:0]    count,
  input  logic                wrap,
  input  logic [WIDTH-1:0]    duty,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic [DT_WIDTH-1:0] deadtime,
`ifdef STV_PWM_POLARITY_EN
  input  logic                pol_h,
  input  logic                pol_l,
`endif
  output logic                pwm_h,
  output logic                pwm_l,
  output logic [WIDTH-1:0]    duty_active,
  output logic                period_start
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOW_ON  = 3'd1;
  localparam logic [2:0] DT_RISE = 3'd2;
  localparam logic [2:0] HIGH_ON = 3'd3;
  localparam logic [2:0] DT_FALL = 3'd4;

  localparam logic [DT_WIDTH-1:0] DT_ONE = 1;

  logic [2:0]          state;
  logic [2:0]          state_d;
  logic [DT_WIDTH-1:0] dt_cnt;
  logic [DT_WIDTH-1:0] dt_cnt_d;
  logic                raw_q;
  logic [WIDTH-1:0]    pend;
  logic                pend_vld;
  logic                fsm_h;
  logic                fsm_l;
  logic                inv_h;
  logic                inv_l;

  assign duty_ready = !pend_vld;

  // Pending duty only moves to the active copy at a period boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend         <= '0;
      pend_vld     <= 1'b0;
      duty_active  <= INIT_DUTY;
      period_start <= 1'b0;
      raw_q        <= 1'b0;
    end else begin
      period_start <= wrap;
      raw_q        <= count < duty_active;
      if (wrap && pend_vld) begin
        duty_active <= pend;
        pend_vld    <= 1'b0;
      end else if (duty_valid && duty_ready) begin
        pend     <= duty;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state;
    dt_cnt_d = dt_cnt;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: state_d = raw_q ? HIGH_ON : LOW_ON;
        LOW_ON: begin
          if (raw_q) begin
            if (deadtime == '0) begin
              state_d = HIGH_ON;
            end else begin
              state_d  = DT_RISE;
              dt_cnt_d = deadtime - DT_ONE;
            end
          end
        end
        DT_RISE: begin
          if (!raw_q)
            state_d = LOW_ON;
          else if (dt_cnt == '0)
            state_d = HIGH_ON;
          else
            dt_cnt_d = dt_cnt - DT_ONE;
        end
        HIGH_ON: begin
          if (!raw_q) begin
            if (deadtime == '0) begin
              state_d = LOW_ON;
            end else begin
              state_d  = DT_FALL;
              dt_cnt_d = deadtime - DT_ONE;
            end
          end
        end
        DT_FALL: begin
          if (raw_q)
            state_d = HIGH_ON;
          else if (dt_cnt == '0)
            state_d = LOW_ON;
          else
            dt_cnt_d = dt_cnt - DT_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fsm_h = (state_d == HIGH_ON);
  assign fsm_l = (state_d == LOW_ON);

`ifdef STV_PWM_POLARITY_EN
  assign inv_h = pol_h;
  assign inv_l = pol_l;
`else
  assign inv_h = 1'b0;
  assign inv_l = 1'b0;
`endif

  // Outputs are registered alongside the state so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_h  <= inv_h;
      pwm_l  <= inv_l;
    end else begin
      state  <= state_d;
      dt_cnt <= dt_cnt_d;
      pwm_h  <= fsm_h ^ inv_h;
      pwm_l  <= fsm_l ^ inv_l;
    end
  end

endmodule

// File: tb/tb_stv_pwm_deadtime.sv
// Bench for stv_pwm_deadtime: directed scenarios plus random traffic
// checked against a behavioural model of duty buffering and dead time.
module tb_stv_pwm_deadtime;

`ifdef STV_PWM_POLARITY_EN
  localparam bit POL_H = 1'b1;
  localparam bit POL_L = 1'b0;
`else
  localparam bit POL_H = 1'b0;
  localparam bit POL_L = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] count = '0;
  logic       wrap = 1'b0;
  logic [7:0] duty = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic [5:0] deadtime = '0;
  logic       pwm_h;
  logic       pwm_l;
  logic [7:0] duty_active;
  logic       period_start;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int per = 10;

  always #5 clk = ~clk;

  stv_pwm_deadtime dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .count        (count),
    .wrap         (wrap),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .deadtime     (deadtime),
`ifdef STV_PWM_POLARITY_EN
    .pol_h        (1'b1),
    .pol_l        (1'b0),
`endif
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .duty_active  (duty_active),
    .period_start (period_start)
  );

  // Model: side = 0 none, 1 low, 2 high. A side switch needs the compare
  // result to disagree with the current side for deadtime+1 samples.
  bit       m_raw, m_pvld, m_pstart, m_acc, m_h, m_l;
  bit [7:0] m_pend, m_dact;
  int       m_side, m_mis, m_dl;

  always @(posedge clk) begin
    bit       raw_old;
    bit       pv_old;
    bit [7:0] dact_old;
    raw_old  = m_raw;
    pv_old   = m_pvld;
    dact_old = m_dact;
    m_acc    = 1'b0;
    if (!rst_n) begin
      m_raw = 0; m_pvld = 0; m_pstart = 0;
      m_dact = 8'd0; m_pend = 8'd0;
      m_side = 0; m_mis = 0; m_dl = 0;
    end else begin
      if (!enable) begin
        m_side = 0; m_mis = 0;
      end else if (m_side == 0) begin
        m_side = raw_old ? 2 : 1; m_mis = 0;
      end else if ((m_side == 2) == raw_old) begin
        m_mis = 0;
      end else begin
        if (m_mis == 0) m_dl = int'(deadtime);
        m_mis++;
        if (m_mis > m_dl) begin
          m_side = raw_old ? 2 : 1; m_mis = 0;
        end
      end
      m_raw = (count < dact_old);
      m_acc = duty_valid && !pv_old;
      if (wrap && pv_old) begin
        m_dact = m_pend; m_pvld = 0;
      end else if (m_acc) begin
        m_pend = duty; m_pvld = 1;
      end
      m_pstart = wrap;
    end
    m_h = (m_side == 2) && (m_mis == 0);
    m_l = (m_side == 1) && (m_mis == 0);
  end

  wire [11:0] dut_vec = {pwm_h, pwm_l, duty_ready, period_start, duty_active};

  function automatic logic [11:0] exp_vec();
    return {m_h ^ POL_H, m_l ^ POL_L, !m_pvld, m_pstart, m_dact};
  endfunction

  // Continuous safety check on the un-inverted drive levels.
  always @(negedge clk) begin
    checks++;
    if ((pwm_h ^ POL_H) && (pwm_l ^ POL_L)) begin
      errors++;
      $display("FAIL overlap t=%0t h=%b l=%b required not both", $time, pwm_h, pwm_l);
    end
  end

  task automatic adv();
    @(negedge clk);
    if (m_acc) duty_valid = 1'b0;
    count = 8'(cnt);
    wrap  = (cnt >= per - 1);
    cnt   = (cnt >= per - 1) ? 0 : cnt + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adv();
    adv();
    checks++;
    if (dut_vec !== {POL_H, POL_L, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_vals got %h exp %h", dut_vec, {POL_H, POL_L, 1'b1, 1'b0, 8'd0});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_handshake();
    int nh = 0;
    int nl = 0;
    bit seen = 0;
    enable = 1'b1;
    deadtime = 6'd0;
    for (int i = 0; i < 30; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hs_idle cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i >= 20) begin nh += int'(pwm_h); nl += int'(pwm_l); end
    end
    checks++;
    if (nh != 0 || nl != 10) begin
      errors++;
      $display("FAIL hs_duty0 h=%0d l=%0d required h=0 l=10", nh, nl);
    end
    for (int i = 0; i < 20 && count != 8'd4; i++) adv();
    duty = 8'd4;
    duty_valid = 1'b1;
    adv();
    checks++;
    if (duty_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_drop got %b required 0", duty_ready);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hs_apply cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (period_start) begin
        seen = 1;
        checks++;
        if (duty_active !== 8'd4) begin
          errors++;
          $display("FAIL hs_active got %0d required 4", duty_active);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL hs_timeout no period_start required within 20 cycles");
    end
    nh = 0;
    for (int i = 0; i < 30; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hs_run cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i >= 20) nh += int'(pwm_h);
    end
    checks++;
    if (nh != 4) begin
      errors++;
      $display("FAIL hs_h_width got %0d required 4", nh);
    end
  endtask

  task automatic test_deadtime();
    int nh = 0;
    int nl = 0;
    duty = 8'd5;
    duty_valid = 1'b1;
    deadtime = 6'd3;
    for (int i = 0; i < 40; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL dt cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i >= 30) begin nh += int'(pwm_h); nl += int'(pwm_l); end
    end
    checks++;
    if (nh != 2 || nl != 2) begin
      errors++;
      $display("FAIL dt_widths h=%0d l=%0d required h=2 l=2", nh, nl);
    end
  endtask

  task automatic test_short_pulse();
    int nh = 0;
    int nl = 0;
    duty = 8'd1;
    duty_valid = 1'b1;
    deadtime = 6'd3;
    for (int i = 0; i < 40; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL short cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i >= 20) nh += int'(pwm_h);
      if (i >= 30) nl += int'(pwm_l);
    end
    checks++;
    if (nh != 0 || nl != 9) begin
      errors++;
      $display("FAIL short_absorb h=%0d l=%0d required h=0 l=9", nh, nl);
    end
  endtask

  task automatic test_wrap_accept();
    logic [7:0] old;
    bit seen = 0;
    for (int i = 0; i < 20 && !wrap; i++) adv();
    old = duty_active;
    duty = 8'd7;
    duty_valid = 1'b1;
    adv();
    checks++;
    if (duty_active !== old || duty_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_accept act=%0d rdy=%b required act=%0d rdy=0", duty_active, duty_ready, old);
    end
    duty = 8'd9;
    duty_valid = 1'b1;
    adv();
    checks++;
    if (duty_ready !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL wrap_holdoff got %h exp %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_run cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (period_start) begin
        seen = 1;
        checks++;
        if (duty_active !== 8'd7) begin
          errors++;
          $display("FAIL wrap_apply got %0d required 7", duty_active);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wrap_timeout no period_start required within 20 cycles");
    end
    for (int i = 0; i < 25; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_tail cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_disable_reset();
    bit hit = 0;
    duty = 8'd8;
    duty_valid = 1'b1;
    deadtime = 6'd0;
    for (int i = 0; i < 40 && !hit; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL dis_run cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      hit = m_h && (i > 25);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL dis_timeout high side required within 40 cycles");
    end
    enable = 1'b0;
    adv();
    checks++;
    if (pwm_h !== POL_H || pwm_l !== POL_L) begin
      errors++;
      $display("FAIL dis_off h=%b l=%b required off", pwm_h, pwm_l);
    end
    enable = 1'b1;
    adv();
    checks++;
    if (((pwm_h ^ POL_H) | (pwm_l ^ POL_L)) !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL dis_reenable got %h exp %h", dut_vec, exp_vec());
    end
    duty = 8'd3;
    duty_valid = 1'b1;
    adv();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    checks++;
    if (dut_vec !== {POL_H, POL_L, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", dut_vec, {POL_H, POL_L, 1'b1, 1'b0, 8'd0});
    end
    for (int i = 0; i < 25; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rst_run cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (duty_active !== 8'd0) begin
      errors++;
      $display("FAIL rst_pend_lost got %0d required 0", duty_active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      adv();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
      if (!duty_valid && $urandom_range(0, 7) == 0) begin
        duty = 8'($urandom_range(0, 18));
        duty_valid = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) deadtime = 6'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) enable = !enable;
      if ($urandom_range(0, 99) == 0) cnt = $urandom_range(0, 15);
      if ($urandom_range(0, 199) == 0) per = $urandom_range(6, 16);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_deadtime();
    test_short_pulse();
    test_wrap_accept();
    test_disable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
